// File: rtl/snes_port_pkg.sv
// Shared types and constants for the SNES controller-port reader.
package snes_port_pkg;

  // Read sequencer states
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LATCH  = 3'd1,
    ST_CLK_LO = 3'd2,
    ST_CLK_HI = 3'd3,
    ST_FINISH = 3'd4
  } port_state_e;

  // PPU counter width and controller data lines
  localparam int HV_W      = 9;
  localparam int PORT_DI_W = 2;

  // Super Scope report (8 bits, first-received bit at [7])
  localparam int SCOPE_BITS      = 8;
  localparam int SCOPE_FIRE      = 7;
  localparam int SCOPE_CURSOR    = 6;
  localparam int SCOPE_TURBO     = 5;
  localparam int SCOPE_PAUSE     = 4;
  localparam int SCOPE_OFFSCREEN = 1;
  localparam int SCOPE_NOISE     = 0;

  // Justifier report (32 bits, first-received bit at [31])
  localparam int          JUST_BITS     = 32;
  localparam int          JUST_ID_HI    = 19;
  localparam int          JUST_ID_LO    = 16;
  localparam logic [3:0]  JUST_ID_VALUE = 4'hE;
  localparam int          JUST_TRIG1    = 7;
  localparam int          JUST_TRIG2    = 6;
  localparam int          JUST_START1   = 5;
  localparam int          JUST_START2   = 4;
  localparam int          JUST_ACTIVE   = 3;

  // Cycles from START pulse to DONE pulse
  function automatic int unsigned read_cycles(input int unsigned bits, input int unsigned div);
    return 1 + 2 * div * (bits + 1);
  endfunction

endpackage

// File: rtl/port_sync.sv
// Two-flop synchronizer for a pad-level input plus a falling-edge detector
// on the synchronized value.
module port_sync #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic async_i,
  output logic sync_o,
  output logic fall_o
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  // Synchronizer chain; prev_q holds the previous synchronized value for edge detect
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
      prev_q <= RST_VAL;
    end else begin
      meta_q <= async_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign sync_o = sync_q;
  assign fall_o = prev_q & ~sync_q;

endmodule

// File: rtl/ctrl_port_reader.sv
// Console-side controller-port master: latch/clock sequencer with serial
// capture on D0/D1, and an IOBit-triggered PPU H/V counter latch.
// CLK_DIV must be at least 3 so the synchronized data settles before sampling.
module ctrl_port_reader
  import snes_port_pkg::*;
#(
  parameter int BITS    = 16,
  parameter int CLK_DIV = 6
) (
  input  logic                 CLK,
  input  logic                 RESET_N,
  input  logic                 START,
  output logic                 BUSY,
  output logic                 DONE,
  output logic                 PORT_LATCH,
  output logic                 PORT_CLK,
  input  logic [PORT_DI_W-1:0] PORT_DI,
  output logic [BITS-1:0]      DATA0,
  output logic [BITS-1:0]      DATA1,
  input  logic                 PORT_P6,
  input  logic                 LATCH_EN,
  input  logic                 SW_LATCH,
  input  logic [HV_W-1:0]      HCNT,
  input  logic [HV_W-1:0]      VCNT,
  output logic [HV_W-1:0]      OPHCT,
  output logic [HV_W-1:0]      OPVCT,
  output logic                 OPLATCHED,
  input  logic                 OPCLR
);

  localparam int PH_W = $clog2(2 * CLK_DIV);
  localparam int BC_W = $clog2(BITS + 1);

  localparam logic [PH_W-1:0] PH_LATCH_LAST = PH_W'(2 * CLK_DIV - 1);
  localparam logic [PH_W-1:0] PH_HALF_LAST  = PH_W'(CLK_DIV - 1);
  localparam logic [PH_W-1:0] PH_ONE        = PH_W'(1);
  localparam logic [BC_W-1:0] BC_LAST       = BC_W'(BITS);
  localparam logic [BC_W-1:0] BC_ONE        = BC_W'(1);

  // Synchronized pad inputs
  logic d0_sync;
  logic d1_sync;
  logic p6_fall;
  logic d0_fall_unused;
  logic d1_fall_unused;
  logic p6_sync_unused;

  port_sync #(.RST_VAL(1'b1)) u_sync_p6 (
    .clk_i   (CLK),
    .rst_ni  (RESET_N),
    .async_i (PORT_P6),
    .sync_o  (p6_sync_unused),
    .fall_o  (p6_fall)
  );

  port_sync #(.RST_VAL(1'b1)) u_sync_d0 (
    .clk_i   (CLK),
    .rst_ni  (RESET_N),
    .async_i (PORT_DI[0]),
    .sync_o  (d0_sync),
    .fall_o  (d0_fall_unused)
  );

  port_sync #(.RST_VAL(1'b1)) u_sync_d1 (
    .clk_i   (CLK),
    .rst_ni  (RESET_N),
    .async_i (PORT_DI[1]),
    .sync_o  (d1_sync),
    .fall_o  (d1_fall_unused)
  );

  // Sequencer state and registered outputs
  port_state_e     state_q;
  logic [PH_W-1:0] phase_q;
  logic [BC_W-1:0] bitcnt_q;
  logic [BITS-1:0] shift0_q;
  logic [BITS-1:0] shift1_q;
  logic [BITS-1:0] data0_q;
  logic [BITS-1:0] data1_q;
  logic            busy_q;
  logic            done_q;
  logic            latch_q;
  logic            pclk_q;

  // Read sequencer: latch strobe, BITS clock periods, then publish inverted shift registers
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q  <= ST_IDLE;
      phase_q  <= '0;
      bitcnt_q <= '0;
      shift0_q <= '0;
      shift1_q <= '0;
      data0_q  <= '0;
      data1_q  <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      latch_q  <= 1'b0;
      pclk_q   <= 1'b1;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          phase_q  <= '0;
          bitcnt_q <= '0;
          if (START) begin
            state_q <= ST_LATCH;
            busy_q  <= 1'b1;
            latch_q <= 1'b1;
          end
        end
        ST_LATCH: begin
          if (phase_q == PH_LATCH_LAST) begin
            phase_q <= '0;
            state_q <= ST_CLK_LO;
            latch_q <= 1'b0;
            pclk_q  <= 1'b0;
          end else begin
            phase_q <= phase_q + PH_ONE;
          end
        end
        ST_CLK_LO: begin
          if (phase_q == PH_HALF_LAST) begin
            phase_q  <= '0;
            state_q  <= ST_CLK_HI;
            pclk_q   <= 1'b1;
            shift0_q <= {shift0_q[BITS-2:0], d0_sync};
            shift1_q <= {shift1_q[BITS-2:0], d1_sync};
            bitcnt_q <= bitcnt_q + BC_ONE;
          end else begin
            phase_q <= phase_q + PH_ONE;
          end
        end
        ST_CLK_HI: begin
          if (phase_q == PH_HALF_LAST) begin
            phase_q <= '0;
            if (bitcnt_q == BC_LAST) begin
              state_q <= ST_FINISH;
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
              data0_q <= ~shift0_q;
              data1_q <= ~shift1_q;
            end else begin
              state_q <= ST_CLK_LO;
              pclk_q  <= 1'b0;
            end
          end else begin
            phase_q <= phase_q + PH_ONE;
          end
        end
        ST_FINISH: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
          phase_q <= '0;
          busy_q  <= 1'b0;
          latch_q <= 1'b0;
          pclk_q  <= 1'b1;
        end
      endcase
    end
  end

  assign BUSY       = busy_q;
  assign DONE       = done_q;
  assign PORT_LATCH = latch_q;
  assign PORT_CLK   = pclk_q;
  assign DATA0      = data0_q;
  assign DATA1      = data1_q;

  // Counter latch: first enabled light hit wins, software latch always overwrites
  logic [HV_W-1:0] ophct_q, ophct_d;
  logic [HV_W-1:0] opvct_q, opvct_d;
  logic            oplatched_q, oplatched_d;
  logic            capture;

  // Next-state for the H/V latch; a capture takes priority over a clear
  always_comb begin
    capture     = SW_LATCH | (p6_fall & LATCH_EN & ~oplatched_q);
    ophct_d     = ophct_q;
    opvct_d     = opvct_q;
    oplatched_d = oplatched_q;
    if (capture) begin
      ophct_d     = HCNT;
      opvct_d     = VCNT;
      oplatched_d = 1'b1;
    end else if (OPCLR) begin
      oplatched_d = 1'b0;
    end
  end

  // H/V latch registers, independent of the read sequencer
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      ophct_q     <= '0;
      opvct_q     <= '0;
      oplatched_q <= 1'b0;
    end else begin
      ophct_q     <= ophct_d;
      opvct_q     <= opvct_d;
      oplatched_q <= oplatched_d;
    end
  end

  assign OPHCT     = ophct_q;
  assign OPVCT     = opvct_q;
  assign OPLATCHED = oplatched_q;

endmodule

// File: tb/tb_ctrl_port_reader.sv
// Bench for ctrl_port_reader: an 8-bit/DIV=4 Super Scope port and a
// 16-bit/DIV=3 joypad port, each driven by a behavioural peripheral model.
module tb_ctrl_port_reader;
  import snes_port_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  logic start8, start16;
  logic [1:0] di8, di16;
  logic p6, latch_en, sw_latch, opclr;
  logic [8:0] hcnt, vcnt;

  logic busy8, done8, latch8, pclk8, oplat8;
  logic [7:0] d0_8, d1_8;
  logic [8:0] oph8, opv8;
  logic busy16, done16, latch16, pclk16, oplat16;
  logic [15:0] d0_16, d1_16;
  logic [8:0] oph16, opv16;

  int vectors = 0;
  int miscompares = 0;

  // Peripheral reports (1 = pressed) and model bit pointers
  logic [7:0]  rep0_8, rep1_8;
  logic [15:0] rep0_16, rep1_16;
  int idx8 = 0, idx16 = 0;
  logic pclk8_prev = 1'b1, pclk16_prev = 1'b1;

  // Expected light-latch state
  logic [8:0] exp_h, exp_v;
  logic       exp_l;

  always #5 clk = ~clk;

  ctrl_port_reader #(.BITS(8), .CLK_DIV(4)) u8 (
    .CLK(clk), .RESET_N(rst_n), .START(start8), .BUSY(busy8), .DONE(done8),
    .PORT_LATCH(latch8), .PORT_CLK(pclk8), .PORT_DI(di8), .DATA0(d0_8), .DATA1(d1_8),
    .PORT_P6(p6), .LATCH_EN(latch_en), .SW_LATCH(sw_latch), .HCNT(hcnt), .VCNT(vcnt),
    .OPHCT(oph8), .OPVCT(opv8), .OPLATCHED(oplat8), .OPCLR(opclr)
  );

  ctrl_port_reader #(.BITS(16), .CLK_DIV(3)) u16 (
    .CLK(clk), .RESET_N(rst_n), .START(start16), .BUSY(busy16), .DONE(done16),
    .PORT_LATCH(latch16), .PORT_CLK(pclk16), .PORT_DI(di16), .DATA0(d0_16), .DATA1(d1_16),
    .PORT_P6(p6), .LATCH_EN(latch_en), .SW_LATCH(sw_latch), .HCNT(hcnt), .VCNT(vcnt),
    .OPHCT(oph16), .OPVCT(opv16), .OPLATCHED(oplat16), .OPCLR(opclr)
  );

  // Pad line level for report bit i of a b-bit report: active low, released after the last bit
  function automatic logic padbit(input logic [15:0] r, input int i, input int b);
    if (i >= b) return 1'b1;
    return ~r[b-1-i];
  endfunction

  assign di8  = {padbit({8'h00, rep1_8}, idx8, 8), padbit({8'h00, rep0_8}, idx8, 8)};
  assign di16 = {padbit(rep1_16, idx16, 16), padbit(rep0_16, idx16, 16)};

  // Peripheral shift model: latch reloads bit 0, each PORT_CLK rise advances one bit
  always @(negedge clk) begin
    if (latch8) idx8 <= 0;
    else if (pclk8 && !pclk8_prev) idx8 <= idx8 + 1;
    pclk8_prev <= pclk8;
    if (latch16) idx16 <= 0;
    else if (pclk16 && !pclk16_prev) idx16 <= idx16 + 1;
    pclk16_prev <= pclk16;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    vectors++;
    assert (obs === want) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
    end
  endtask

  // One complete read on the selected port; START re-pulsed at cycles re1/re2 (0 = none)
  task automatic run_read(input bit sel, input int re1, input int re2);
    int b, d, exp_lat, budget, lat, ndone, nlrise, nclkfall;
    logic prev_l, prev_c, cur_l, cur_c, cur_done, cur_busy, busy_at_done;
    logic [15:0] old0, cur0, got0, got1, exp0, exp1;
    b = sel ? 16 : 8;
    d = sel ? 3 : 4;
    exp_lat = 1 + 2 * d * (b + 1);
    budget = exp_lat + 20;
    exp0 = sel ? rep0_16 : {8'h00, rep0_8};
    exp1 = sel ? rep1_16 : {8'h00, rep1_8};
    old0 = sel ? d0_16 : {8'h00, d0_8};
    prev_l = sel ? latch16 : latch8;
    prev_c = sel ? pclk16 : pclk8;
    lat = -1; ndone = 0; nlrise = 0; nclkfall = 0;
    got0 = 'x; got1 = 'x; busy_at_done = 1'bx;
    if (sel) start16 = 1'b1; else start8 = 1'b1;
    for (int k = 1; k <= budget; k++) begin
      @(negedge clk);
      if (sel) start16 = (k == re1) || (k == re2);
      else     start8  = (k == re1) || (k == re2);
      cur_l    = sel ? latch16 : latch8;
      cur_c    = sel ? pclk16 : pclk8;
      cur_done = sel ? done16 : done8;
      cur_busy = sel ? busy16 : busy8;
      cur0     = sel ? d0_16 : {8'h00, d0_8};
      if (k == 1) chk("busy_after_start", {31'd0, cur_busy}, 32'd1);
      if (k == exp_lat - 1) chk("data_hold", {16'd0, cur0}, {16'd0, old0});
      if (cur_l && !prev_l) nlrise++;
      if (!cur_c && prev_c) nclkfall++;
      if (cur_done) begin
        ndone++;
        if (lat < 0) begin
          lat = k;
          got0 = cur0;
          got1 = sel ? d1_16 : {8'h00, d1_8};
          busy_at_done = cur_busy;
        end
      end
      prev_l = cur_l;
      prev_c = cur_c;
    end
    if (sel) start16 = 1'b0; else start8 = 1'b0;
    chk("done_latency", lat, exp_lat);
    chk("done_count", ndone, 1);
    chk("latch_pulses", nlrise, 1);
    chk("clk_low_pulses", nclkfall, b);
    chk("data0", {16'd0, got0}, {16'd0, exp0});
    chk("data1", {16'd0, got1}, {16'd0, exp1});
    chk("busy_at_done", {31'd0, busy_at_done}, 32'd0);
  endtask

  // P6 high->low; OPCLR optionally asserted in the cycle the synced fall is seen
  task automatic p6_fall(input bit with_clr);
    p6 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    if (with_clr) opclr = 1'b1;
    @(negedge clk);
    opclr = 1'b0;
    repeat (2) @(negedge clk);
    p6 = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic sw_pulse();
    sw_latch = 1'b1;
    @(negedge clk);
    sw_latch = 1'b0;
    @(negedge clk);
  endtask

  task automatic clr_pulse();
    opclr = 1'b1;
    @(negedge clk);
    opclr = 1'b0;
    @(negedge clk);
  endtask

  // Reference rules for the counter latch
  task automatic model_fall(input bit with_clr);
    if (latch_en && !exp_l) begin
      exp_h = hcnt; exp_v = vcnt; exp_l = 1'b1;
    end else if (with_clr) begin
      exp_l = 1'b0;
    end
  endtask

  task automatic check_light(input string tag);
    chk({tag, "_ophct"}, {23'd0, oph8}, {23'd0, exp_h});
    chk({tag, "_opvct"}, {23'd0, opv8}, {23'd0, exp_v});
    chk({tag, "_oplatched"}, {31'd0, oplat8}, {31'd0, exp_l});
    chk({tag, "_ophct16"}, {23'd0, oph16}, {23'd0, exp_h});
    chk({tag, "_opvct16"}, {23'd0, opv16}, {23'd0, exp_v});
    chk({tag, "_oplatched16"}, {31'd0, oplat16}, {31'd0, exp_l});
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ndone;
    int op;
    rst_n = 1'b0;
    start8 = 1'b0; start16 = 1'b0;
    p6 = 1'b1; latch_en = 1'b0; sw_latch = 1'b0; opclr = 1'b0;
    hcnt = '0; vcnt = '0;
    rep0_8 = '0; rep1_8 = '0; rep0_16 = '0; rep1_16 = '0;
    exp_h = '0; exp_v = '0; exp_l = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst_pclk", {31'd0, pclk8}, 32'd1);
    chk("rst_latch", {31'd0, latch8}, 32'd0);
    chk("rst_busy", {31'd0, busy8}, 32'd0);
    chk("rst_done", {31'd0, done8}, 32'd0);
    chk("rst_data0", {24'd0, d0_8}, 32'd0);
    chk("rst_pclk16", {31'd0, pclk16}, 32'd1);
    chk("rst_data0_16", {16'd0, d0_16}, 32'd0);
    check_light("rst");

    // Super Scope, fire + turbo held, D1 released; START coincides with reset release
    rep0_8 = 8'((1 << SCOPE_FIRE) | (1 << SCOPE_TURBO));
    rep1_8 = 8'h00;
    rst_n = 1'b1;
    run_read(1'b0, 0, 0);
    chk("scope_word", {24'd0, d0_8}, 32'h0000_00A0);

    // 16-bit pad: idle, then D0 tied low
    rep0_16 = 16'h0000; rep1_16 = 16'h0000;
    run_read(1'b1, 0, 0);
    chk("pad_idle", {16'd0, d0_16}, 32'h0000_0000);
    rep0_16 = 16'hFFFF;
    run_read(1'b1, 0, 0);
    chk("pad_tied", {16'd0, d0_16}, 32'h0000_FFFF);

    // Random reports on both ports
    for (int i = 0; i < 4; i++) begin
      rep0_8 = 8'($urandom); rep1_8 = 8'($urandom);
      run_read(1'b0, 0, 0);
      rep0_16 = 16'($urandom); rep1_16 = 16'($urandom);
      run_read(1'b1, 0, 0);
    end

    // START re-pulsed during a read, then in the FINISH cycle
    rep0_8 = 8'($urandom); rep1_8 = 8'($urandom);
    run_read(1'b0, 5, 40);
    rep0_8 = 8'($urandom); rep1_8 = 8'($urandom);
    run_read(1'b0, 73, 0);

    // Light latch: first hit wins
    latch_en = 1'b1; hcnt = 9'd120; vcnt = 9'd96;
    p6_fall(1'b0); model_fall(1'b0);
    check_light("first_hit");
    hcnt = 9'd130;
    p6_fall(1'b0); model_fall(1'b0);
    check_light("second_hit");

    // Clear alone, clear coinciding with a hit, clear again, disabled hit, software latch
    clr_pulse(); exp_l = 1'b0;
    check_light("clr");
    hcnt = 9'd200;
    p6_fall(1'b1); model_fall(1'b1);
    check_light("clr_vs_hit");
    chk("clr_vs_hit_h200", {23'd0, oph8}, 32'd200);
    clr_pulse(); exp_l = 1'b0;
    check_light("clr2");
    latch_en = 1'b0; hcnt = 9'd50;
    p6_fall(1'b0); model_fall(1'b0);
    check_light("disabled");
    hcnt = 9'd77; vcnt = 9'd33;
    sw_pulse(); exp_h = hcnt; exp_v = vcnt; exp_l = 1'b1;
    check_light("sw");

    // Random counter-latch operations
    for (int i = 0; i < 10; i++) begin
      op = int'($urandom_range(0, 2));
      hcnt = 9'($urandom); vcnt = 9'($urandom);
      latch_en = 1'($urandom);
      if (op == 0) begin
        sw_pulse(); exp_h = hcnt; exp_v = vcnt; exp_l = 1'b1;
      end else if (op == 1) begin
        p6_fall(1'b0); model_fall(1'b0);
      end else begin
        clr_pulse(); exp_l = 1'b0;
      end
      check_light("rand_light");
    end

    // Reset during bit 5 of a read
    rep0_8 = 8'hFF; rep1_8 = 8'h5A;
    run_read(1'b0, 0, 0);
    rep0_8 = 8'($urandom); rep1_8 = 8'($urandom);
    start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    repeat (48) @(negedge clk);
    chk("midread_pclk_low", {31'd0, pclk8}, 32'd0);
    chk("midread_busy", {31'd0, busy8}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rstmid_pclk", {31'd0, pclk8}, 32'd1);
    chk("rstmid_latch", {31'd0, latch8}, 32'd0);
    chk("rstmid_data0", {24'd0, d0_8}, 32'd0);
    chk("rstmid_data1", {24'd0, d1_8}, 32'd0);
    chk("rstmid_busy", {31'd0, busy8}, 32'd0);
    exp_h = '0; exp_v = '0; exp_l = 1'b0;
    check_light("rstmid");
    ndone = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (done8) ndone++;
    end
    rst_n = 1'b1;
    for (int k = 0; k < 80; k++) begin
      @(negedge clk);
      if (done8) ndone++;
    end
    chk("rstmid_no_done", ndone, 0);
    rep0_8 = 8'($urandom); rep1_8 = 8'($urandom);
    run_read(1'b0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
